// File: rtl/us_array_scan.sv
// Round-robin multi-channel HC-SR04 ranging controller: fires one sensor at a time,
// measures echo width in prescaled ticks and publishes packed 16-bit distances.
module us_array_scan #(
  parameter int NUM_CH        = 9,
  parameter int CLK_DIV       = 500,
  parameter int TRIGGER_TICKS = 1,
  parameter int MAX_COUNT     = 3800,
  parameter int GAP_TICKS     = 6000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_CH-1:0]     ch_mask,
  input  logic [NUM_CH-1:0]     echo,
  output logic [NUM_CH-1:0]     trigger,
  output logic [16*NUM_CH-1:0]  dists,
  output logic [NUM_CH-1:0]     valid,
  output logic [NUM_CH-1:0]     timeout,
  output logic                  frame_done,
  output logic [7:0]            frame_cnt,
  output logic                  busy
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [IW-1:0] LAST_CH   = IW'(NUM_CH - 1);
  localparam logic [PW-1:0] PRESC_TOP = PW'(CLK_DIV - 1);
  localparam logic [15:0]   MAXC      = 16'(MAX_COUNT);
  localparam logic [15:0]   CNT_LAST  = 16'(MAX_COUNT - 1);
  localparam logic [15:0]   TRIG_LAST = 16'(TRIGGER_TICKS - 1);
  localparam logic [15:0]   GAP_END   = 16'(GAP_TICKS);

  typedef enum logic [2:0] {IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, GAP, DONE} state_t;

  state_t             state;
  logic [NUM_CH-1:0]  sync1, sync2, sync3;
  logic [NUM_CH-1:0]  frame_mask;
  logic [PW-1:0]      presc;
  logic [IW-1:0]      idx;
  logic [15:0]        count;
  logic               tick;
  logic               echo_now;
  logic               echo_prev;

  assign tick      = (presc == PRESC_TOP);
  assign echo_now  = sync2[idx];
  assign echo_prev = sync3[idx];

  // sync3 is only the previous synchronised sample, used for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= echo;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      presc      <= '0;
      count      <= '0;
      frame_mask <= '0;
      trigger    <= '0;
      dists      <= '0;
      valid      <= '0;
      timeout    <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      busy       <= 1'b0;
    end else begin
      presc      <= tick ? '0 : presc + PW'(1);
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && (|ch_mask)) begin
            frame_mask <= ch_mask;
            idx        <= '0;
            busy       <= 1'b1;
            state      <= SELECT;
          end
        end
        SELECT: begin
          if (frame_mask[idx]) begin
            // restart the prescaler so the trigger lasts exactly TRIGGER_TICKS ticks
            trigger[idx] <= 1'b1;
            presc        <= '0;
            count        <= '0;
            state        <= TRIG;
          end else begin
            valid[idx]   <= 1'b0;
            timeout[idx] <= 1'b0;
            if (idx == LAST_CH) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              state      <= DONE;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end
        TRIG: begin
          if (tick) begin
            if (count == TRIG_LAST) begin
              trigger[idx] <= 1'b0;
              count        <= '0;
              state        <= WAIT_RISE;
            end else begin
              count <= count + 16'd1;
            end
          end
        end
        WAIT_RISE: begin
          if (echo_now && !echo_prev) begin
            count <= '0;
            state <= MEASURE;
          end else if (tick) begin
            if (count == CNT_LAST) begin
              dists[16*idx +: 16] <= MAXC;
              valid[idx]          <= 1'b0;
              timeout[idx]        <= 1'b1;
              count               <= '0;
              state               <= GAP;
            end else begin
              count <= count + 16'd1;
            end
          end
        end
        MEASURE: begin
          if (!echo_now && echo_prev) begin
            dists[16*idx +: 16] <= count;
            valid[idx]          <= 1'b1;
            timeout[idx]        <= 1'b0;
            count               <= '0;
            state               <= GAP;
          end else if (tick && echo_now) begin
            if (count == CNT_LAST) begin
              dists[16*idx +: 16] <= MAXC;
              valid[idx]          <= 1'b0;
              timeout[idx]        <= 1'b1;
              count               <= '0;
              state               <= GAP;
            end else begin
              count <= count + 16'd1;
            end
          end
        end
        GAP: begin
          // a stuck-high echo holds us here so it cannot ring into the next slot
          if (count != GAP_END) begin
            if (tick) count <= count + 16'd1;
          end else if (!echo_now) begin
            count <= '0;
            if (idx == LAST_CH) begin
              frame_done <= 1'b1;
              frame_cnt  <= frame_cnt + 8'd1;
              state      <= DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= SELECT;
            end
          end
        end
        DONE: begin
          if (enable && (|ch_mask)) begin
            frame_mask <= ch_mask;
            idx        <= '0;
            state      <= SELECT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_us_array_scan.sv
// Directed bench for us_array_scan with 3 channels and short timing parameters;
// a background responder plays the sensors and records trigger/frame activity.
module tb_us_array_scan;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [2:0]  ch_mask;
  logic [2:0]  echo;
  logic [2:0]  trigger;
  logic [47:0] dists;
  logic [2:0]  valid;
  logic [2:0]  timeout;
  logic        frame_done;
  logic [7:0]  frame_cnt;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  int width [3];
  int echo_left [3];
  int trig_cycles [3];
  int trig_seen [3];
  int fall_cyc [3];
  int order [$];
  int fd_count = 0;
  int fd_cyc = 0;
  int cyc = 0;
  int onehot_err = 0;
  logic [2:0] trig_prev;

  us_array_scan #(
    .NUM_CH(3), .CLK_DIV(4), .TRIGGER_TICKS(1), .MAX_COUNT(20), .GAP_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask), .echo(echo),
    .trigger(trigger), .dists(dists), .valid(valid), .timeout(timeout),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sensor model: echo rises as the trigger falls and stays high width[c] clocks
  initial begin
    echo      = '0;
    trig_prev = '0;
    for (int c = 0; c < 3; c++) begin
      echo_left[c] = 0;
      fall_cyc[c]  = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (rst) begin
        for (int c = 0; c < 3; c++) echo_left[c] = 0;
        echo = '0;
      end else begin
        for (int c = 0; c < 3; c++) begin
          if (trigger[c]) trig_cycles[c]++;
          if (trigger[c] && !trig_prev[c]) begin
            trig_seen[c]++;
            order.push_back(c);
          end
          if (!trigger[c] && trig_prev[c]) echo_left[c] = width[c];
          if (echo_left[c] > 0) begin
            echo[c] = 1'b1;
            echo_left[c]--;
          end else begin
            if (echo[c]) fall_cyc[c] = cyc;
            echo[c] = 1'b0;
          end
        end
        if (frame_done) begin
          fd_count++;
          fd_cyc = cyc;
        end
        if ($countones(trigger) > 1) onehot_err++;
      end
      trig_prev = trigger;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] mask, input int w0, input int w1, input int w2);
    width[0] = w0;
    width[1] = w1;
    width[2] = w2;
    fd_count = 0;
    for (int c = 0; c < 3; c++) begin
      trig_cycles[c] = 0;
      trig_seen[c]   = 0;
    end
    order.delete();
    @(negedge clk);
    ch_mask = mask;
    enable  = 1'b1;
    @(negedge clk);
    enable  = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && busy; i++) @(negedge clk);
    checkOutput("reach_idle", 32'(busy), 0);
  endtask

  task automatic waitTrigger(input int c, input logic level);
    for (int i = 0; i < 500 && trigger[c] !== level; i++) @(negedge clk);
    checkOutput("wait_trigger", 32'(trigger[c]), 32'(level));
  endtask

  int d;
  int first_ch;
  int second_ch;

  initial begin
    rst     = 1'b1;
    enable  = 1'b0;
    ch_mask = '0;
    for (int c = 0; c < 3; c++) begin
      width[c]       = 0;
      trig_cycles[c] = 0;
      trig_seen[c]   = 0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_trigger", 32'(trigger), 0);
    checkOutput("rst_dists_lo", dists[31:0], 0);
    checkOutput("rst_dists_hi", 32'(dists[47:32]), 0);
    checkOutput("rst_valid", 32'(valid), 0);
    checkOutput("rst_timeout", 32'(timeout), 0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);

    $display("[TB] single echo on channel 0");
    applyStimulus(3'b001, 40, 0, 0);
    waitIdle(3000);
    d = int'(dists[15:0]);
    checkOutput("trig0_width", 32'(trig_cycles[0]), 4);
    checkOutput("ch0_dist_in_9_10", 32'(d == 9 || d == 10), 1);
    checkOutput("single_valid", 32'(valid), 3'b001);
    checkOutput("single_timeout", 32'(timeout), 0);
    checkOutput("single_frame_done", 32'(fd_count), 1);
    checkOutput("single_frame_cnt", 32'(frame_cnt), 1);

    $display("[TB] no echo on channel 1");
    applyStimulus(3'b010, 0, 0, 0);
    waitIdle(3000);
    checkOutput("noecho_dist1", 32'(dists[31:16]), 20);
    checkOutput("noecho_timeout", 32'(timeout), 3'b010);
    checkOutput("noecho_valid", 32'(valid), 0);
    checkOutput("noecho_frame_done", 32'(fd_count), 1);
    checkOutput("noecho_frame_cnt", 32'(frame_cnt), 2);

    $display("[TB] stuck-high echo on channel 2");
    applyStimulus(3'b100, 0, 0, 200);
    waitIdle(3000);
    checkOutput("stuck_dist2", 32'(dists[47:32]), 20);
    checkOutput("stuck_timeout", 32'(timeout), 3'b100);
    checkOutput("stuck_valid", 32'(valid), 0);
    checkOutput("stuck_gap_exit_after_fall", 32'(fd_cyc - fall_cyc[2]), 3);
    checkOutput("stuck_dist1_kept", 32'(dists[31:16]), 20);

    $display("[TB] masked scan of channels 0 and 2");
    applyStimulus(3'b101, 20, 0, 48);
    waitIdle(3000);
    first_ch  = (order.size() > 0) ? order[0] : -1;
    second_ch = (order.size() > 1) ? order[1] : -1;
    d = int'(dists[15:0]);
    checkOutput("mask_ch0_dist_in_4_5", 32'(d == 4 || d == 5), 1);
    d = int'(dists[47:32]);
    checkOutput("mask_ch2_dist_in_11_12", 32'(d == 11 || d == 12), 1);
    checkOutput("mask_trig1_never", 32'(trig_seen[1]), 0);
    checkOutput("mask_order_size", 32'(order.size()), 2);
    checkOutput("mask_first", 32'(first_ch), 0);
    checkOutput("mask_second", 32'(second_ch), 2);
    checkOutput("mask_valid", 32'(valid), 3'b101);
    checkOutput("mask_timeout", 32'(timeout), 0);
    checkOutput("mask_dist1_kept", 32'(dists[31:16]), 20);

    $display("[TB] mask change during a frame");
    applyStimulus(3'b101, 20, 0, 48);
    @(negedge clk);
    ch_mask = 3'b010;
    waitIdle(3000);
    checkOutput("mchg_trig1_never", 32'(trig_seen[1]), 0);
    checkOutput("mchg_trig0_seen", 32'(trig_seen[0]), 1);
    checkOutput("mchg_trig2_seen", 32'(trig_seen[2]), 1);
    checkOutput("mchg_valid", 32'(valid), 3'b101);
    checkOutput("mchg_timeout", 32'(timeout), 0);
    checkOutput("mchg_frame_cnt", 32'(frame_cnt), 5);

    $display("[TB] reset during measurement");
    applyStimulus(3'b001, 40, 0, 0);
    waitTrigger(0, 1'b1);
    waitTrigger(0, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mrst_trigger", 32'(trigger), 0);
    checkOutput("mrst_dists_lo", dists[31:0], 0);
    checkOutput("mrst_dists_hi", 32'(dists[47:32]), 0);
    checkOutput("mrst_valid", 32'(valid), 0);
    checkOutput("mrst_timeout", 32'(timeout), 0);
    checkOutput("mrst_frame_cnt", 32'(frame_cnt), 0);
    checkOutput("mrst_busy", 32'(busy), 0);

    $display("[TB] reset while trigger is high");
    applyStimulus(3'b001, 40, 0, 0);
    waitTrigger(0, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("trst_trigger", 32'(trigger), 0);
    checkOutput("trst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] 256 continuous frames then stop");
    width[0] = 8;
    width[1] = 0;
    width[2] = 0;
    fd_count = 0;
    ch_mask  = 3'b001;
    enable   = 1'b1;
    for (int i = 0; i < 20000 && fd_count < 255; i++) @(negedge clk);
    checkOutput("wrap_fd_255", 32'(fd_count), 255);
    checkOutput("wrap_frame_cnt_255", 32'(frame_cnt), 255);
    repeat (2) @(negedge clk);
    checkOutput("stop_busy_mid", 32'(busy), 1);
    enable = 1'b0;
    waitIdle(3000);
    checkOutput("stop_fd_256", 32'(fd_count), 256);
    checkOutput("wrap_frame_cnt_0", 32'(frame_cnt), 0);
    checkOutput("stop_valid", 32'(valid), 3'b001);
    repeat (5) @(negedge clk);
    checkOutput("stop_stays_idle", 32'(busy), 0);
    checkOutput("stop_fd_final", 32'(fd_count), 256);

    checkOutput("trigger_onehot", 32'(onehot_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/us_array_scan.md
Name: us_array_scan

Overview:
- Parametrised multi-channel HC-SR04 ranging controller that generalises the per-sensor free-running instances.
- Fires sensors one at a time, round-robin, with an inter-channel guard gap, so neighbouring transducers cannot crosstalk.
- Has its own tick prescaler, per-channel enable mask, timeout flags and a frame counter.
- Sits between the echo/trigger pins and the mojo_com tx array, which it feeds as packed 16-bit distances.

Parameters:
- NUM_CH, 9, number of sensors (1..16).
- CLK_DIV, 500, clk cycles per measurement tick (500 = 10 us at 50 MHz).
- TRIGGER_TICKS, 1, trigger pulse width in ticks.
- MAX_COUNT, 3800, tick limit for echo wait and echo width; must be < 65536.
- GAP_TICKS, 6000, guard ticks after each channel before the next trigger (60 ms).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  run continuous frames while high
- ch_mask  in  NUM_CH  channel enables; bit i=1 means scan channel i
- echo  in  NUM_CH  asynchronous echo inputs
- trigger  out  NUM_CH  trigger outputs; at most one high at a time
- dists  out  16*NUM_CH  last distance in ticks; channel i at [16*i+15:16*i]
- valid  out  NUM_CH  distance for channel i is from a completed echo
- timeout  out  NUM_CH  last attempt on channel i hit MAX_COUNT
- frame_done  out  1  one-cycle pulse at end of each frame
- frame_cnt  out  8  completed frames, wraps 255->0
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, channel index 0, prescaler 0, synchronisers cleared. Reset mid-operation drops trigger on the next edge and clears all results.
- Echo inputs pass through a 2-flop synchroniser; edge detection uses the synchronised value.
- Tick: prescaler counts 0..CLK_DIV-1 and pulses tick on wrap. It is zeroed on entry to TRIG so pulse widths are exact.
- FSM states: IDLE, SELECT, TRIG, WAIT_RISE, MEASURE, GAP, DONE.
- IDLE -> SELECT when enable=1 and ch_mask!=0.
  - Latch ch_mask into the frame mask; index=0.
- SELECT: if index is not set in the frame mask, skip it.
  - Clear valid and timeout for that channel; dists is retained; index++.
  - After NUM_CH-1 -> DONE. Set index -> TRIG.
  - Skipping one channel costs one clk.
- TRIG: trigger[index]=1 for exactly TRIGGER_TICKS ticks, then -> WAIT_RISE with tick count=0.
- WAIT_RISE: wait for a synchronised 0->1 on echo[index]. Echo already high at entry does not count.
  - Rise -> MEASURE, count=0.
  - Count reaches MAX_COUNT -> timeout path.
- MEASURE: count++ per tick while echo is high.
  - Falling edge: dists[index]=count, valid=1, timeout=0, registered one clk after the synchronised fall detect -> GAP.
  - Count reaches MAX_COUNT: timeout path.
- Timeout path: dists[index]=MAX_COUNT, valid=0, timeout=1 -> GAP.
- GAP: wait GAP_TICKS ticks, then wait until echo[index] is synchronised-low. index++ -> SELECT, or -> DONE after the last channel.
- DONE: frame_done=1 for one clk; frame_cnt++ (wraps).
  - enable=1 and ch_mask!=0 -> SELECT with index=0 and re-latched mask.
  - Otherwise -> IDLE.
- enable dropping mid-frame: the current frame completes normally, then IDLE.
- ch_mask changing mid-frame has no effect until the next frame.
- Counters are 16 bits; count never exceeds MAX_COUNT.
- Measurement quantisation is -1/+0 ticks relative to true echo width / tick period.
- Outputs are registered and stable between updates; each channel's result updates only in its own slot.

Test Plan:
- Bench params: NUM_CH=3, CLK_DIV=4, MAX_COUNT=20, GAP_TICKS=3, TRIGGER_TICKS=1.
- Reset: assert rst 2 cycles mid-MEASURE -> next cycle trigger=0, dists=0, valid=0, timeout=0, frame_cnt=0, busy=0.
- Single echo: mask=001, enable=1, echo[0] high for 40 clks after trigger falls -> trigger[0] high exactly 4 clks; dists[15:0] in {9,10}; valid=001; one frame_done pulse; frame_cnt=1.
- No echo: mask=010, echo[1] held low -> dists[31:16]=20, timeout=010, valid=000, frame_done once.
- Stuck high: echo[2] high for 200 clks -> dists[47:32]=20, timeout[2]=1; GAP exits only after echo[2] falls.
- Masking and order: mask=101, distinct echo widths 5 and 12 ticks -> trigger[1] never asserts; trigger[0] precedes trigger[2]; valid=101.
- Mask change mid-frame is ignored until the next frame.
- Wrap and stop: run 256 frames with mask=001 -> frame_cnt returns to 0. Drop enable mid-frame -> that frame completes, frame_done pulses, then busy=0.
